operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 145 ++++++++++++++
 tb/tb_operand_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Operand loader: debounced pushbutton steps through LOAD_A, LOAD_B and LOAD_OP,
// then strobes enable for one EXEC cycle so the ALU runs on the captured values.
module operand_loader #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       taster,
   input  logic [3:0] sw,
   output logic [3:0] registar_a,
   output logic [3:0] registar_b,
   output logic [1:0] operation,
   output logic       enable,
   output logic [1:0] phase
);

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      LOAD_OP = 2'd2,
      EXEC    = 2'd3
   } state_t;

   localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

   logic        rst_meta_r;
   logic        rst_ready_r;
   logic        srst_s;
   logic        sync1_r;
   logic        sync2_r;
   logic        deb_r;
   logic        deb_d_r;
   logic        press_r;
   logic [19:0] cnt_r;
   state_t      state_r;
   logic [3:0]  a_r;
   logic [3:0]  b_r;
   logic [1:0]  op_r;
   logic        en_r;

   // Reset release synchronizer: assertion is immediate, deassertion takes two edges
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta_r  <= 1'b0;
         rst_ready_r <= 1'b0;
      end else begin
         rst_meta_r  <= 1'b1;
         rst_ready_r <= rst_meta_r;
      end
   end

   assign srst_s = ~rst_ready_r;

   // Button synchronizer, debounce counter and registered press event
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         deb_r   <= 1'b1;
         deb_d_r <= 1'b1;
         press_r <= 1'b0;
         cnt_r   <= 20'd0;
      end else if (srst_s) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         deb_r   <= 1'b1;
         deb_d_r <= 1'b1;
         press_r <= 1'b0;
         cnt_r   <= 20'd0;
      end else begin
         sync1_r <= taster;
         sync2_r <= sync1_r;
         deb_d_r <= deb_r;
         // Only a falling debounced level is a press; release is silent
         press_r <= deb_d_r & ~deb_r;
         if (sync2_r == deb_r) begin
            cnt_r <= 20'd0;
         end else if (cnt_r == CNT_MAX) begin
            deb_r <= sync2_r;
            cnt_r <= 20'd0;
         end else begin
            cnt_r <= cnt_r + 20'd1;
         end
      end
   end

   // Load sequencer with registered ALU-facing outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= LOAD_A;
         a_r     <= 4'd0;
         b_r     <= 4'd0;
         op_r    <= 2'd0;
         en_r    <= 1'b0;
      end else if (srst_s) begin
         state_r <= LOAD_A;
         a_r     <= 4'd0;
         b_r     <= 4'd0;
         op_r    <= 2'd0;
         en_r    <= 1'b0;
      end else begin
         en_r <= 1'b0;
         case (state_r)
            LOAD_A: begin
               if (press_r) begin
                  a_r     <= sw;
                  state_r <= LOAD_B;
               end else begin
                  state_r <= LOAD_A;
               end
            end
            LOAD_B: begin
               if (press_r) begin
                  b_r     <= sw;
                  state_r <= LOAD_OP;
               end else begin
                  state_r <= LOAD_B;
               end
            end
            LOAD_OP: begin
               if (press_r) begin
                  op_r    <= sw[1:0];
                  en_r    <= 1'b1;
                  state_r <= EXEC;
               end else begin
                  state_r <= LOAD_OP;
               end
            end
            EXEC: begin
               state_r <= LOAD_A;
            end
            default: begin
               state_r <= LOAD_A;
            end
         endcase
      end
   end

   assign registar_a = a_r;
   assign registar_b = b_r;
   assign operation  = op_r;
   assign enable     = en_r;
   assign phase      = state_r;

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader with a short debounce window.
module tb_operand_loader;

   localparam int DEB = 4;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] op;
   } exp_t;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       taster  = 1'b1;
   logic [3:0] sw      = 4'd0;
   logic [3:0] registar_a;
   logic [3:0] registar_b;
   logic [1:0] operation;
   logic       enable;
   logic [1:0] phase;

   int   checks     = 0;
   int   failures   = 0;
   int   en_cycles  = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   operand_loader #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .taster     (taster),
      .sw         (sw),
      .registar_a (registar_a),
      .registar_b (registar_b),
      .operation  (operation),
      .enable     (enable),
      .phase      (phase)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] v);
      @(posedge clock);
      #2;
      sw     = v;
      taster = 1'b0;
      repeat (12) @(posedge clock);
      #2;
      taster = 1'b1;
      repeat (12) @(posedge clock);
      @(negedge clock);
   endtask

   // Each enable cycle consumes one expected ALU operand set
   always @(negedge clock) begin
      if (reset_n && enable) begin
         en_cycles++;
         check_val("exec_phase", 32'(phase), 32'd3);
         if (sb_q.size() == 0) begin
            check_val("exec_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check_val("exec_a", 32'(registar_a), 32'(mon_e.a));
            check_val("exec_b", 32'(registar_b), 32'(mon_e.b));
            check_val("exec_op", 32'(operation), 32'(mon_e.op));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      #23;
      check_val("rst_a", 32'(registar_a), 32'd0);
      check_val("rst_b", 32'(registar_b), 32'd0);
      check_val("rst_op", 32'(operation), 32'd0);
      check_val("rst_en", 32'(enable), 32'd0);
      check_val("rst_phase", 32'(phase), 32'd0);
      @(posedge clock);
      #2;
      reset_n = 1'b1;
      repeat (5) @(posedge clock);

      // Clean three-press sequence
      sb_q.push_back('{a: 4'd5, b: 4'd3, op: 2'd2});
      press(4'd5);
      check_val("clean_a", 32'(registar_a), 32'd5);
      check_val("clean_ph1", 32'(phase), 32'd1);
      press(4'd3);
      check_val("clean_b", 32'(registar_b), 32'd3);
      check_val("clean_ph2", 32'(phase), 32'd2);
      press(4'd2);
      check_val("clean_ph0", 32'(phase), 32'd0);
      check_val("clean_op", 32'(operation), 32'd2);
      check_val("clean_keep_a", 32'(registar_a), 32'd5);
      check_val("clean_en_cnt", 32'(en_cycles), 32'd1);

      // Long hold yields one event only
      @(posedge clock);
      #2;
      sw     = 4'd7;
      taster = 1'b0;
      repeat (100) @(posedge clock);
      @(negedge clock);
      check_val("hold_phase", 32'(phase), 32'd1);
      check_val("hold_a", 32'(registar_a), 32'd7);
      taster = 1'b1;
      repeat (12) @(posedge clock);
      @(negedge clock);
      check_val("hold_release", 32'(phase), 32'd1);
      press(4'd8);
      check_val("hold_next_ph", 32'(phase), 32'd2);
      check_val("hold_b", 32'(registar_b), 32'd8);
      sb_q.push_back('{a: 4'd7, b: 4'd8, op: 2'd1});
      press(4'd1);
      check_val("hold_exec_ph", 32'(phase), 32'd0);
      check_val("hold_en_cnt", 32'(en_cycles), 32'd2);

      // Press latency: capture on edge N+7
      @(posedge clock);
      #2;
      sw     = 4'd6;
      taster = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock);
         @(negedge clock);
         if (k < 7) check_val("lat_early", 32'(registar_a), 32'd7);
         else       check_val("lat_edge", 32'(registar_a), 32'd6);
      end
      check_val("lat_phase", 32'(phase), 32'd1);
      taster = 1'b1;
      repeat (12) @(posedge clock);
      press(4'd1);
      sb_q.push_back('{a: 4'd6, b: 4'd1, op: 2'd0});
      press(4'd0);
      check_val("lat_en_cnt", 32'(en_cycles), 32'd3);

      // Bounce: short low burst is ignored, capture 7 edges after final low
      @(posedge clock);
      #2;
      sw     = 4'd9;
      taster = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      taster = 1'b1;
      repeat (2) @(posedge clock);
      #2;
      taster = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock);
         @(negedge clock);
         if (k < 7) check_val("bounce_early", 32'(registar_a), 32'd6);
         else       check_val("bounce_edge", 32'(registar_a), 32'd9);
      end
      check_val("bounce_phase", 32'(phase), 32'd1);
      taster = 1'b1;
      repeat (12) @(posedge clock);
      press(4'd2);
      check_val("bounce_b", 32'(registar_b), 32'd2);

      // Switch noise without presses changes nothing
      for (int i = 0; i < 20; i++) begin
         @(posedge clock);
         #2;
         sw = ~sw;
      end
      @(negedge clock);
      check_val("noise_a", 32'(registar_a), 32'd9);
      check_val("noise_b", 32'(registar_b), 32'd2);
      check_val("noise_op", 32'(operation), 32'd0);
      check_val("noise_phase", 32'(phase), 32'd2);
      check_val("noise_en_cnt", 32'(en_cycles), 32'd3);

      // Asynchronous reset in LOAD_OP clears everything at once
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("arst_a", 32'(registar_a), 32'd0);
      check_val("arst_b", 32'(registar_b), 32'd0);
      check_val("arst_op", 32'(operation), 32'd0);
      check_val("arst_en", 32'(enable), 32'd0);
      check_val("arst_phase", 32'(phase), 32'd0);
      #10;
      @(negedge clock);
      #2;
      reset_n = 1'b1;
      repeat (4) @(posedge clock);
      @(negedge clock);
      check_val("arst_idle", 32'(phase), 32'd0);
      press(4'd4);
      check_val("arst_new_a", 32'(registar_a), 32'd4);
      check_val("arst_new_ph", 32'(phase), 32'd1);
      check_val("arst_new_b", 32'(registar_b), 32'd0);

      check_val("sb_empty", 32'(sb_q.size()), 32'd0);
      check_val("en_total", 32'(en_cycles), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
